// File: rtl/mdr_arbiter_sched_if.sv
// mdr_arbiter_sched_if: requester, MDR datapath and response signals of the scheduler
interface mdr_arbiter_sched_if #(parameter int DW = 16);
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]    req0_op, req1_op, mdr_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0] mdr_a, mdr_b, mdr_rem, rsp_rem;
  logic          mdr_start, mdr_done, rsp_valid, rsp_id, rsp_err;
  logic [2*DW-1:0] mdr_result, rsp_result;
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    input  mdr_done, mdr_result, mdr_rem,
    output req0_ready, req1_ready, mdr_start, mdr_op, mdr_a, mdr_b,
    output rsp_valid, rsp_id, rsp_result, rsp_rem, rsp_err
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    output mdr_done, mdr_result, mdr_rem,
    input  req0_ready, req1_ready, mdr_start, mdr_op, mdr_a, mdr_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_rem, rsp_err
  );
endinterface

// File: rtl/mdr_arbiter_sched.sv
// mdr_arbiter_sched: round-robin sharing of one MDR datapath between two requesters with watchdog
module mdr_arbiter_sched #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  mdr_arbiter_sched_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, next;
  logic last_grant, id, err, gnt0, gnt1, take, div0, bad, timeout;
  logic [CW-1:0] cnt;
  logic [2*DW-1:0] res;
  logic [DW-1:0] rem, sel_a, sel_b;
  logic [1:0] sel_op;
  // on a tie the requester that was not served last wins
  always_comb begin
    gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    take = (state == IDLE) && (gnt0 || gnt1);
    sel_op = gnt0 ? bus.req0_op : bus.req1_op;
    sel_a = gnt0 ? bus.req0_a : bus.req1_a;
    sel_b = gnt0 ? bus.req0_b : bus.req1_b;
    div0 = (sel_op == 2'b01) && (sel_b == '0);
    bad = (sel_op == 2'b11) || div0;
    timeout = cnt == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = take ? (bad ? RESP : ISSUE) : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = (bus.mdr_done || timeout) ? RESP : WAIT;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bus.req0_ready = (state == IDLE) && !rst && gnt0;
    bus.req1_ready = (state == IDLE) && !rst && gnt1;
    bus.mdr_start = state == ISSUE;
    bus.rsp_valid = state == RESP;
    bus.rsp_id = bus.rsp_valid && id;
    bus.rsp_err = bus.rsp_valid && err;
    bus.rsp_result = bus.rsp_valid ? res : '0;
    bus.rsp_rem = bus.rsp_valid ? rem : '0;
  end
  // watchdog is compared before incrementing, so it never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      id <= 1'b0;
      err <= 1'b0;
      res <= '0;
      rem <= '0;
      cnt <= '0;
      bus.mdr_op <= '0;
      bus.mdr_a <= '0;
      bus.mdr_b <= '0;
    end else begin
      if (take) begin
        id <= gnt1;
        err <= bad;
        res <= div0 ? '1 : '0;
        rem <= div0 ? sel_a : '0;
        bus.mdr_op <= sel_op;
        bus.mdr_a <= sel_a;
        bus.mdr_b <= sel_b;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        if (bus.mdr_done) begin
          res <= bus.mdr_result;
          rem <= bus.mdr_rem;
          err <= 1'b0;
        end else if (timeout) begin
          res <= '0;
          rem <= '0;
          err <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
      if (state == RESP) last_grant <= id;
    end
  end
endmodule

// File: tb/tb_mdr_arbiter_sched.sv
// tb_mdr_arbiter_sched: directed scoreboard bench with a latency-programmable MDR model
module tb_mdr_arbiter_sched;
  localparam int DW = 16;
  localparam int TO = 8;
  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [15:0] rem;
    logic        err;
    int          cyc;
  } exp_t;
  logic clk = 1'b1;
  logic rst;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int lat = 1;
  int start_cnt = 0;
  int start_cyc = -1;
  int rsp_cnt = 0;
  int mcnt = 0;
  logic [1:0] m_op;
  logic [15:0] m_a, m_b;
  exp_t sb[$];
  mdr_arbiter_sched_if #(.DW(DW)) bus();
  mdr_arbiter_sched #(.DW(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [47:0] mdr_calc(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    r = 0;
    if (op == 2'b00) return {16'd0, 32'(a) * 32'(b)};
    if (op == 2'b01) return {a % b, 32'(a / b)};
    while ((r + 1) * (r + 1) <= 32'(a)) r++;
    return {16'd0, r};
  endfunction
  // MDR datapath model plus response monitor, both sampled away from the clock edge
  always @(negedge clk) begin
    logic [47:0] v;
    exp_t e;
    bus.mdr_done = 1'b0;
    bus.mdr_result = '0;
    bus.mdr_rem = '0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        v = mdr_calc(m_op, m_a, m_b);
        bus.mdr_done = 1'b1;
        bus.mdr_result = v[31:0];
        bus.mdr_rem = v[47:32];
      end
    end
    if (bus.mdr_start) begin
      start_cnt++;
      start_cyc = cyc;
      m_op = bus.mdr_op;
      m_a = bus.mdr_a;
      m_b = bus.mdr_b;
      mcnt = lat < 0 ? 0 : lat;
    end
    if (bus.rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) chk("rsp_unexpected", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_result", bus.rsp_result, e.res);
        chk("rsp_rem", bus.rsp_rem, e.rem);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic tick_in();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input bit v);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask
  task automatic wait_grant(output int t, output bit gid);
    bit found;
    found = 0;
    t = -1;
    gid = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        chk("both_ready", bus.req0_ready & bus.req1_ready, 0);
        found = 1;
        t = cyc;
        gid = bus.req1_ready;
      end
    end
    chk("grant_seen", found, 1);
  endtask
  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 0);
    sb.delete();
  endtask
  task automatic reset_pulse();
    tick_in();
    rst = 1;
    tick_in();
    rst = 0;
  endtask
  task automatic one_op(input bit id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int l,
                        input logic [31:0] er, input logic [15:0] erm, input bit ee, input int delta, input int nstart);
    int t, s0;
    bit g;
    lat = l;
    s0 = start_cnt;
    tick_in();
    drive(id, op, a, b, 1);
    wait_grant(t, g);
    chk("grant_id", g, id);
    sb.push_back('{id, er, erm, ee, t + delta});
    tick_in();
    drive(id, op, a, b, 0);
    drain(TO + 20);
    chk("start_count", 64'(start_cnt - s0), 64'(nstart));
    if (nstart == 1) chk("start_cycle", 64'(start_cyc), 64'(t + 1));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end
  initial begin
    int t, r0;
    bit g;
    rst = 1;
    drive(0, 2'b00, 16'd1, 16'd1, 1);
    drive(1, 2'b00, 16'd0, 16'd0, 0);
    repeat (2) @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_start", bus.mdr_start, 0);
    chk("rst_mdr_op", bus.mdr_op, 0);
    chk("rst_mdr_a", bus.mdr_a, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    tick_in();
    rst = 0;
    drive(0, 2'b00, 16'd0, 16'd0, 0);
    one_op(0, 2'b00, 16'd7, 16'd6, 5, 32'd42, 16'd0, 0, 7, 1);
    one_op(1, 2'b10, 16'd200, 16'd0, 1, 32'd14, 16'd0, 0, 3, 1);
    reset_pulse();
    lat = 2;
    tick_in();
    drive(0, 2'b00, 16'd3, 16'd5, 1);
    drive(1, 2'b01, 16'd100, 16'd7, 1);
    for (int k = 0; k < 4; k++) begin
      wait_grant(t, g);
      chk("rr_order", g, 64'(k % 2));
      sb.push_back('{g, g ? 32'd14 : 32'd15, g ? 16'd2 : 16'd0, 1'b0, t + 4});
      @(negedge clk);
      chk("ready_pulse", bus.req0_ready | bus.req1_ready, 0);
    end
    tick_in();
    drive(0, 2'b00, 16'd0, 16'd0, 0);
    drive(1, 2'b00, 16'd0, 16'd0, 0);
    drain(40);
    one_op(1, 2'b01, 16'd9, 16'd0, 2, 32'hffff_ffff, 16'd9, 1, 1, 0);
    one_op(0, 2'b11, 16'd5, 16'd5, 2, 32'd0, 16'd0, 1, 1, 0);
    lat = 2;
    tick_in();
    drive(0, 2'b00, 16'd3, 16'd5, 1);
    drive(1, 2'b01, 16'd100, 16'd7, 1);
    wait_grant(t, g);
    chk("tie_after_err", g, 1);
    sb.push_back('{1'b1, 32'd14, 16'd2, 1'b0, t + 4});
    tick_in();
    drive(0, 2'b00, 16'd0, 16'd0, 0);
    drive(1, 2'b00, 16'd0, 16'd0, 0);
    drain(30);
    one_op(0, 2'b00, 16'd7, 16'd6, -1, 32'd0, 16'd0, 1, TO + 2, 1);
    one_op(0, 2'b00, 16'd7, 16'd6, TO, 32'd42, 16'd0, 0, TO + 2, 1);
    lat = 5;
    r0 = rsp_cnt;
    tick_in();
    drive(0, 2'b00, 16'd7, 16'd6, 1);
    wait_grant(t, g);
    tick_in();
    drive(0, 2'b00, 16'd0, 16'd0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("wrst_start", bus.mdr_start, 0);
    chk("wrst_mdr_op", bus.mdr_op, 0);
    chk("wrst_mdr_a", bus.mdr_a, 0);
    chk("wrst_mdr_b", bus.mdr_b, 0);
    chk("wrst_rsp_valid", bus.rsp_valid, 0);
    chk("wrst_rsp_result", bus.rsp_result, 0);
    chk("wrst_rsp_err", bus.rsp_err, 0);
    repeat (5) @(negedge clk);
    chk("wrst_no_rsp", 64'(rsp_cnt - r0), 0);
    one_op(1, 2'b00, 16'd4, 16'd4, 3, 32'd16, 16'd0, 0, 5, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mdr_arbiter_sched.md
# mdr_arbiter_sched

Round-robin scheduler that shares one multiply/divide/root (MDR) datapath between two requesters. It accepts one operation at a time, screens out illegal requests, issues the operation to the MDR datapath, and waits for completion under a watchdog. It returns the result tagged with the requester ID. It sits between client logic and the MDR top, replacing direct client drive of the datapath's start/operand inputs.

## Interface
Parameters:
- DW, 16, operand width.
- TIMEOUT, 64, maximum number of WAIT cycles before abort. Must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  2  operation: 00 MULT, 01 DIV, 10 SQRT, 11 reserved.
- req0_a, req0_b  in  DW each  operands; b is ignored for SQRT.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- mdr_start  out  1  one-cycle start pulse to the MDR datapath.
- mdr_op  out  2  registered operation.
- mdr_a, mdr_b  out  DW each  registered operands.
- mdr_done  in  1  MDR completion.
- mdr_result  in  2*DW  MDR product, quotient or root, zero-extended.
- mdr_rem  in  DW  MDR remainder (DIV only).
- rsp_valid  out  1  response valid, one-cycle pulse, no backpressure.
- rsp_id  out  1  requester the response belongs to.
- rsp_result  out  2*DW  response result.
- rsp_rem  out  DW  response remainder.
- rsp_err  out  1  response is an error.

## Operation
- States:
  - IDLE: the only state that accepts requests.
    - If any reqX_valid is high, grant one requester: if both are valid, the requester ≠ last_grant wins.
    - reqX_ready is high combinationally in IDLE for the granted requester only.
    - Capture op/a/b into the mdr_* registers and record id.
    - Illegal op (11), or DIV with b == 0: go to RESP with err = 1, without issuing.
    - Otherwise go to ISSUE.
  - ISSUE: mdr_start = 1; clear the watchdog counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - If mdr_done: latch mdr_result/mdr_rem, go to RESP with err = 0.
    - Else if counter == TIMEOUT-1: go to RESP with err = 1.
  - RESP: rsp_valid = 1 with the latched id/result/rem/err; last_grant ← id; go to IDLE.
- Error results:
  - DIV by zero: rsp_result all ones, rsp_rem = a.
  - Illegal op and timeout: rsp_result = 0, rsp_rem = 0.
- last_grant updates only in RESP, so a granted requester cannot win twice in a row while the other is waiting.
- mdr_op/mdr_a/mdr_b hold stable from ISSUE until the next grant.
- mdr_done outside WAIT is ignored.
- The watchdog counter is $clog2(TIMEOUT) bits wide and never wraps: it is compared before incrementing.

## Timing
- Reset values (rst high at a clk edge):
  - State = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All outputs 0, including mdr_op/a/b and rsp_* fields.
  - reqX_ready = 0 during the rst cycle.
- Legal operation accepted at cycle T:
  - mdr_start at T+1.
  - WAIT from T+2.
  - If mdr_done arrives at cycle W (W ≥ T+2), rsp_valid is at W+1.
- Error path: accepted at T, rsp_valid at T+1, no mdr_start.
- Timeout: with no mdr_done, WAIT occupies T+2 … T+1+TIMEOUT, and rsp_valid with err is at T+2+TIMEOUT.
- mdr_done on the final WAIT cycle takes priority over timeout.
- Earliest next accept is the cycle after RESP. Throughput is one operation per (latency + 3) cycles.
- rst mid-operation:
  - Abandon the operation, with no rsp_valid.
  - Return to IDLE and reset values on the next edge.
  - A late mdr_done is ignored.
- Simultaneous reqX_valid rising while in a non-IDLE state: ignored (ready stays 0) until IDLE.

## Test plan
- Single MULT: req0, a=7, b=6. Model asserts done with result=42, 5 cycles after start.
  - Required: exactly one mdr_start at T+1; rsp_valid at T+7 with id=0, result=42, err=0.
- Contention: req0 and req1 both held valid after reset, 4 operations.
  - Required: grants in the order 0,1,0,1, and each reqX_ready is a single-cycle pulse.
- DIV by zero: req1, a=9, b=0.
  - Required: no mdr_start; rsp_valid at T+1 with id=1, err=1, result=all ones, rem=9.
- Reserved op=11 on req0.
  - Required: rsp_valid at T+1 with err=1, result=0; then a subsequent tie is granted to req1.
- Timeout: TIMEOUT=8, model never asserts done.
  - Required: rsp_valid at T+10 with err=1.
  - Repeat with done on the 8th WAIT cycle: err=0.
- Reset in WAIT: pulse rst 3 cycles after start, then model asserts done.
  - Required: all outputs 0, no rsp_valid, and a fresh request is accepted normally afterward.
